// File: rtl/collatz_pkg.sv
// Shared constants and types for the Collatz tile host driver.
package collatz_pkg;

  localparam int unsigned COLLATZ_BITS   = 144;
  localparam int unsigned COLLATZ_NBYTES = COLLATZ_BITS / 8;

  // uio_in bit positions on the tile pin interface
  localparam int unsigned UIO_WE   = 7;
  localparam int unsigned UIO_KICK = 6;
  localparam int unsigned UIO_PSEL = 5;

  // Read addresses as {path sel, addr[4:0]}
  localparam logic [5:0] ADDR_OLEN_LO = 6'h00;
  localparam logic [5:0] ADDR_OLEN_HI = 6'h01;
  localparam logic [5:0] ADDR_PREC_LO = 6'h20;
  localparam logic [5:0] ADDR_PREC_HI = 6'h21;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StKick,
    StEnter,
    StRun,
    StRead,
    StDone
  } host_state_e;

  // Address presented in each slot of the read pipeline
  function automatic logic [5:0] read_addr(input logic [1:0] slot);
    logic [5:0] addr;
    case (slot)
      2'd0:    addr = ADDR_OLEN_LO;
      2'd1:    addr = ADDR_OLEN_HI;
      2'd2:    addr = ADDR_PREC_LO;
      default: addr = ADDR_PREC_HI;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/collatz_host_driver.sv
// Host-side initiator for the Collatz tile pin protocol: writes a start value bytewise,
// kicks COMPUTE, waits for the tile to return to IO, reads back orbit length and the
// path-record high half, and returns them on a valid/ready response port.
module collatz_host_driver
  import collatz_pkg::*;
#(
  parameter int unsigned BITS           = COLLATZ_BITS,
  parameter int unsigned NBYTES         = COLLATZ_NBYTES,
  parameter int unsigned TIMEOUT_CYCLES = 131072,
  parameter int unsigned ENTER_CYCLES   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [BITS-1:0] cmd_value,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [15:0]     rsp_orbit_len,
  output logic [15:0]     rsp_path_h16,
  output logic            rsp_error,
  output logic [7:0]      dut_ui_in,
  output logic [7:0]      dut_uio_in,
  input  logic [7:0]      dut_uo_out,
  input  logic [7:0]      dut_uio_out,
  input  logic [7:0]      dut_uio_oe
);

  localparam logic [4:0]  LastByte = 5'(NBYTES - 1);
  localparam logic [17:0] EnterLim = 18'(ENTER_CYCLES);
  localparam logic [17:0] RunLim   = 18'(TIMEOUT_CYCLES);

  host_state_e     state_q, state_d;
  logic [BITS-1:0] value_q, value_d;
  // Byte index in WRITE, pipeline slot in READ
  logic [4:0]      idx_q, idx_d;
  logic [17:0]     timer_q, timer_d, timer_inc;
  // Read bytes a00, a01, a20 held until a21 arrives
  logic [23:0]     cap_q, cap_d;
  logic [15:0]     olen_q, olen_d, ph_q, ph_d;
  logic            err_q, err_d;
  logic [7:0]      ui_in_q, ui_in_d, uio_in_q, uio_in_d;
  logic            tile_compute;
  logic            unused_pins;

  assign tile_compute = dut_uio_oe[7];
  assign unused_pins  = ^{dut_uio_out, dut_uio_oe[6:0]};
  assign timer_inc    = (timer_q == '1) ? timer_q : timer_q + 18'd1;

  // Next-state logic: command capture, byte sequencing, timers and read-back capture
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    cap_d   = cap_q;
    olen_d  = olen_q;
    ph_d    = ph_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          value_d = cmd_value;
          idx_d   = 5'd0;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (idx_q == LastByte) begin
          state_d = StKick;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
      StKick: begin
        timer_d = '0;
        state_d = StEnter;
      end
      StEnter: begin
        // The tile may stay in COMPUTE for a single cycle, so oe is checked every cycle
        if (tile_compute) begin
          timer_d = '0;
          state_d = StRun;
        end else begin
          timer_d = timer_inc;
          if (timer_inc >= EnterLim) begin
            err_d   = 1'b1;
            olen_d  = '0;
            ph_d    = '0;
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (!tile_compute) begin
          idx_d   = 5'd0;
          state_d = StRead;
        end else begin
          timer_d = timer_inc;
          if (timer_inc >= RunLim) begin
            err_d   = 1'b1;
            olen_d  = '0;
            ph_d    = '0;
            state_d = StDone;
          end
        end
      end
      StRead: begin
        // Slot k captures the byte addressed in slot k-1 (tile read data is registered)
        idx_d = idx_q + 5'd1;
        case (idx_q)
          5'd1: cap_d[7:0]   = dut_uo_out;
          5'd2: cap_d[15:8]  = dut_uo_out;
          5'd3: cap_d[23:16] = dut_uo_out;
          5'd4: begin
            olen_d  = cap_q[15:0];
            ph_d    = {dut_uo_out, cap_q[23:16]};
            err_d   = 1'b0;
            state_d = StDone;
          end
          default: ;
        endcase
      end
      StDone: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Tile pin values for the upcoming state, so the registered pins line up with it
  always_comb begin
    ui_in_d  = '0;
    uio_in_d = '0;
    unique case (state_d)
      StWrite: begin
        ui_in_d          = value_d[{idx_d, 3'b000} +: 8];
        uio_in_d[UIO_WE] = 1'b1;
        uio_in_d[4:0]    = idx_d;
      end
      StKick: begin
        uio_in_d[UIO_KICK] = 1'b1;
      end
      StRead: begin
        if (idx_d < 5'd4) begin
          uio_in_d[5:0] = read_addr(idx_d[1:0]);
        end
      end
      default: ;
    endcase
  end

  // State, datapath and pin registers; reset drops the tile pins to 0 immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      value_q  <= '0;
      idx_q    <= '0;
      timer_q  <= '0;
      cap_q    <= '0;
      olen_q   <= '0;
      ph_q     <= '0;
      err_q    <= 1'b0;
      ui_in_q  <= '0;
      uio_in_q <= '0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      cap_q    <= cap_d;
      olen_q   <= olen_d;
      ph_q     <= ph_d;
      err_q    <= err_d;
      ui_in_q  <= ui_in_d;
      uio_in_q <= uio_in_d;
    end
  end

  assign cmd_ready     = (state_q == StIdle);
  assign rsp_valid     = (state_q == StDone);
  assign rsp_orbit_len = olen_q;
  assign rsp_path_h16  = ph_q;
  assign rsp_error     = err_q;
  assign dut_ui_in     = ui_in_q;
  assign dut_uio_in    = uio_in_q;

endmodule

// File: tb/tb_collatz_host_driver.sv
// Bench for collatz_host_driver: a behavioural Collatz tile answers the pin protocol,
// stimulus pushes expected responses into a queue and a monitor pops and compares them.
module tb_collatz_host_driver;
  import collatz_pkg::*;

  localparam int unsigned TimeoutCycles = 1000;

  typedef struct packed {
    logic        err;
    logic [15:0] ph;
    logic [15:0] olen;
  } rsp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [143:0] cmd_value = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [15:0]  rsp_orbit_len, rsp_path_h16;
  logic         rsp_error;
  logic [7:0]   dut_ui_in, dut_uio_in, dut_uo_out, dut_uio_out, dut_uio_oe;

  int           total = 0;
  int           bad = 0;
  rsp_t         exp_q[$];
  rsp_t         mon_e;
  logic [143:0] cur_val = '0;
  int           wr_idx = 0;
  bit           tile_deaf = 1'b0;

  // Tile model state
  logic [7:0]   t_uo;
  logic         t_busy;
  logic [143:0] t_mem;
  int           t_cnt;
  logic [15:0]  t_olen, t_ph;

  collatz_host_driver #(
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_value    (cmd_value),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_orbit_len(rsp_orbit_len),
    .rsp_path_h16 (rsp_path_h16),
    .rsp_error    (rsp_error),
    .dut_ui_in    (dut_ui_in),
    .dut_uio_in   (dut_uio_in),
    .dut_uo_out   (dut_uo_out),
    .dut_uio_out  (dut_uio_out),
    .dut_uio_oe   (dut_uio_oe)
  );

  always #5 clk = ~clk;

  // Collatz orbit: steps to reach 1 (16-bit), max value seen (wrapping 144-bit arithmetic),
  // and whether the 65536-step cap was hit. Returns {capped, record[143:128], steps[15:0]}.
  function automatic logic [32:0] golden(input logic [143:0] v);
    logic [143:0] x, rec;
    int n;
    x = v;
    rec = v;
    n = 0;
    while (x != 144'd1 && n < 65536) begin
      if (x[0]) x = x * 3 + 1;
      else      x = x >> 1;
      if (x > rec) rec = x;
      n++;
    end
    return {(x != 144'd1), rec[143:128], n[15:0]};
  endfunction

  function automatic logic [15:0] g_olen(input logic [143:0] v);
    logic [32:0] g;
    g = golden(v);
    return g[15:0];
  endfunction

  function automatic logic [15:0] g_ph(input logic [143:0] v);
    logic [32:0] g;
    g = golden(v);
    return g[31:16];
  endfunction

  // Time the tile spends in COMPUTE: one cycle for an orbit of 1, far beyond the bench
  // timeout when the orbit never closes, otherwise a random few cycles.
  function automatic int tile_lat(input logic [143:0] v);
    logic [32:0] g;
    g = golden(v);
    if (g[32]) return 1500;
    if (g[15:0] == 16'd1) return 1;
    return int'($urandom_range(3, 40));
  endfunction

  function automatic rsp_t model(input logic [143:0] v);
    logic [32:0] g;
    rsp_t r;
    g = golden(v);
    r.err  = g[32];
    r.ph   = g[32] ? 16'd0 : g[31:16];
    r.olen = g[32] ? 16'd0 : g[15:0];
    return r;
  endfunction

  assign dut_uio_oe  = {t_busy, 7'b0};
  assign dut_uio_out = {t_busy, 7'b0};
  assign dut_uo_out  = t_uo;

  // Behavioural tile: byte writes and kick in IO mode, registered read data
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_uo <= '0; t_busy <= 1'b0; t_mem <= '0; t_cnt <= 0; t_olen <= '0; t_ph <= '0;
    end else begin
      case ({dut_uio_in[5], dut_uio_in[4:0]})
        6'h00:   t_uo <= t_olen[7:0];
        6'h01:   t_uo <= t_olen[15:8];
        6'h20:   t_uo <= t_ph[7:0];
        6'h21:   t_uo <= t_ph[15:8];
        default: t_uo <= 8'h5A;
      endcase
      if (t_busy) begin
        if (t_cnt <= 1) t_busy <= 1'b0;
        else            t_cnt <= t_cnt - 1;
      end else begin
        if (dut_uio_in[7] && dut_uio_in[4:0] < 5'd18)
          t_mem[{dut_uio_in[4:0], 3'b000} +: 8] <= dut_ui_in;
        if (dut_uio_in[6] && !tile_deaf) begin
          t_olen <= g_olen(t_mem);
          t_ph   <= g_ph(t_mem);
          t_cnt  <= tile_lat(t_mem);
          t_busy <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expired(input string name);
    total++;
    bad++;
    $display("FAIL %s: actual=timeout required=event", name);
  endtask

  // Pin protocol monitor: write address/data order, kick shape, write count per kick
  always @(negedge clk) begin
    if (!rst_n) begin
      wr_idx = 0;
    end else begin
      if (dut_uio_in[7]) begin
        chk("wr_addr", 64'(dut_uio_in[4:0]), 64'(wr_idx));
        chk("wr_ctl", 64'(dut_uio_in[6:5]), 64'd0);
        chk("wr_data", 64'(dut_ui_in), 64'(cur_val[8*wr_idx +: 8]));
        wr_idx++;
      end
      if (dut_uio_in[6]) begin
        chk("kick_pins", 64'({dut_uio_in, dut_ui_in}), 64'h4000);
        chk("kick_write_count", 64'(wr_idx), 64'd18);
        wr_idx = 0;
      end
    end
  end

  // Scoreboard: compare each accepted response with the oldest expectation
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: actual=olen %0h required=no response", rsp_orbit_len);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_orbit_len", 64'(rsp_orbit_len), 64'(mon_e.olen));
        chk("rsp_path_h16", 64'(rsp_path_h16), 64'(mon_e.ph));
        chk("rsp_error", 64'(rsp_error), 64'(mon_e.err));
      end
    end
  end

  task automatic send(input logic [143:0] v);
    bit ok;
    ok = 1'b0;
    cur_val   = v;
    cmd_value = v;
    cmd_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (!ok) expired("cmd_accept");
  endtask

  // Cycles from the accept edge until rsp_valid is seen
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (lat < 5000) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    if (!rsp_valid) expired("rsp_wait");
  endtask

  task automatic finish_rsp();
    if (!rsp_ready) begin
      repeat ($urandom_range(1, 5)) begin
        @(posedge clk);
        #1;
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run(input logic [143:0] v, input rsp_t e, output int lat);
    exp_q.push_back(e);
    rsp_ready = 1'($urandom_range(0, 1));
    send(v);
    wait_rsp(lat);
    finish_rsp();
    // A timed-out tile is left running; reset it along with the driver
    if (e.err) pulse_reset();
  endtask

  int           lat;
  rsp_t         e, e27, e2;
  logic [159:0] r;
  logic [143:0] v;
  bit           found;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    e27 = '0; e27.olen = 16'h006F;
    e2  = '0; e2.olen  = 16'h0001;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("reset_outputs", 64'({rsp_valid, rsp_error, rsp_orbit_len, rsp_path_h16}), 64'd0);
    chk("reset_pins", 64'({dut_ui_in, dut_uio_in}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(144'd27, e27, lat);
    run(144'd2, e2, lat);
    v = {1'b1, 142'd0, 1'b1};
    run(v, model(v), lat);

    for (int k = 0; k < 100; k++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      v = r[143:0] >> $urandom_range(0, 143);
      run(v, model(v), lat);
    end

    // Tile never enters COMPUTE: error after the enter window
    tile_deaf = 1'b1;
    e = '0; e.err = 1'b1;
    run(144'd27, e, lat);
    chk("enter_timeout_latency", 64'(lat), 64'd24);
    tile_deaf = 1'b0;

    // Start value 0 never reaches 1: run timeout
    run(144'd0, e, lat);
    chk("run_timeout_latency", 64'(lat), 64'd1021);

    // Backpressure with a second command already waiting
    exp_q.push_back(e27);
    rsp_ready = 1'b0;
    send(144'd27);
    wait_rsp(lat);
    cur_val   = 144'd2;
    cmd_value = 144'd2;
    cmd_valid = 1'b1;
    exp_q.push_back(e2);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      chk("hold_rsp", 64'({rsp_valid, cmd_ready, rsp_error, rsp_path_h16, rsp_orbit_len}),
          64'({1'b1, 1'b0, e27.err, e27.ph, e27.olen}));
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("cmd_ready_in_done", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    chk("cmd_ready_after_rsp", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_rsp(lat);
    finish_rsp();

    // Reset during WRITE byte 9
    send(144'h1234_5678_9abc_def0_1357_9bdf_2468_ace0_1111);
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dut_uio_in[7] && dut_uio_in[4:0] == 5'd9) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) expired("write_byte9");
    rst_n = 1'b0;
    #1;
    chk("rst_write_pins", 64'({dut_ui_in, dut_uio_in}), 64'd0);
    chk("rst_write_idle", 64'({cmd_ready, rsp_valid}), 64'b10);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(144'd27, e27, lat);

    // Reset during RUN
    send(144'd27);
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (dut_uio_oe[7]) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) expired("tile_compute");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_run_pins", 64'({dut_ui_in, dut_uio_in}), 64'd0);
    chk("rst_run_idle", 64'({cmd_ready, rsp_valid}), 64'b10);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    v = 144'd97;
    run(v, model(v), lat);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
